// File: rtl/fire_scheduler.sv
// Fire scheduler: picks one excited transition per step (round robin) and issues it on 'fire',
// with a settle cycle after each fire. Optional macro FIRE_RANDOM_EN randomizes the scan start via an LFSR.
module fire_scheduler #(
  parameter int          N               = 8,
  parameter int          FW              = 4,
  parameter int          DEADLOCK_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  excited,
  input  logic          run,
  input  logic          step,
  output logic [FW-1:0] fire,
  output logic          fire_valid,
  output logic          deadlock,
  output logic [31:0]   fire_count,
  output logic          busy
);

  localparam int            SW        = $clog2(DEADLOCK_CYCLES + 1);
  localparam logic [FW-1:0] IDLE_CODE = FW'(N);
  localparam logic [FW-1:0] LAST_IDX  = FW'(N - 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(DEADLOCK_CYCLES);

  if ((2 ** FW) <= N) begin : g_bad_fw
    $error("fire_scheduler: FW too narrow for idle code N");
  end
  if (DEADLOCK_CYCLES < 1) begin : g_bad_dl
    $error("fire_scheduler: DEADLOCK_CYCLES must be >= 1");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("fire_scheduler: LFSR_SEED must be nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_FIRE,
    S_SETTLE,
    S_DEADLOCK
  } state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] fire_q, fire_d;
  logic          fire_valid_q, fire_valid_d;
  logic          deadlock_q, deadlock_d;
  logic [31:0]   count_q, count_d;
  logic [FW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] stall_q, stall_d;
  logic          one_shot_q, one_shot_d;

  logic [FW-1:0] scan_start;
  logic [FW-1:0] sel;
  logic          found;

`ifdef FIRE_RANDOM_EN
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] lfsr_mod;

  // Fibonacci LFSR, taps 16,14,13,11; steps once per issued fire
  always_comb begin
    lfsr_d   = lfsr_q;
    lfsr_mod = lfsr_q % 16'(N);
    if (state_q == S_FIRE) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
    scan_start = lfsr_mod[FW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end
`else
  always_comb begin
    scan_start = ptr_q;
  end
`endif

  // Wrap-around scan: indices >= start take priority over those below it
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && excited[j] && (FW'(j) >= scan_start)) begin
        found = 1'b1;
        sel   = FW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && excited[j]) begin
        found = 1'b1;
        sel   = FW'(j);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    fire_d       = IDLE_CODE;
    one_shot_d   = one_shot_q;
    stall_d      = stall_q;
    ptr_d        = ptr_q;
    count_d      = count_q;
    deadlock_d   = deadlock_q;
    case (state_q)
      S_IDLE: begin
        if (run || step) begin
          state_d    = S_EVAL;
          one_shot_d = step & ~run;
        end
      end
      S_EVAL: begin
        if (!run && !one_shot_q) begin
          state_d = S_IDLE;
        end else if (found) begin
          fire_d  = sel;
          stall_d = '0;
          state_d = S_FIRE;
        end else begin
          stall_d = stall_q + 1'b1;
          if ((stall_q + 1'b1) == STALL_MAX) begin
            state_d    = S_DEADLOCK;
            deadlock_d = 1'b1;
          end
        end
      end
      S_FIRE: begin
        count_d = count_q + 32'd1;
        ptr_d   = (fire_q == LAST_IDX) ? '0 : fire_q + 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        one_shot_d = 1'b0;
        state_d    = run ? S_EVAL : S_IDLE;
      end
      S_DEADLOCK: begin
        state_d = S_DEADLOCK;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    fire_valid_d = (fire_d < IDLE_CODE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      fire_q       <= IDLE_CODE;
      fire_valid_q <= 1'b0;
      deadlock_q   <= 1'b0;
      count_q      <= '0;
      ptr_q        <= '0;
      stall_q      <= '0;
      one_shot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fire_q       <= fire_d;
      fire_valid_q <= fire_valid_d;
      deadlock_q   <= deadlock_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      stall_q      <= stall_d;
      one_shot_q   <= one_shot_d;
    end
  end

  assign fire       = fire_q;
  assign fire_valid = fire_valid_q;
  assign deadlock   = deadlock_q;
  assign fire_count = count_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_DEADLOCK);

endmodule
